ikaopll_bus_sequencer: RTL and testbench

- Host-side write scheduler for the IKAOPLL core.
- Accepts (register address, data) write requests from a system bus over a valid/ready handshake and buffers them in a small FIFO.
- Replays each request onto the core's CS_n/WR_n/A0/D pins with YM2413-legal spacing: 12 phiM ticks after an address write, 84 phiM ticks after a data write.
- Sits between the cartridge/CPU bus decoder and the IKAOPLL instance, so the host never has to insert software delays.

---
 rtl/ikaopll_bus_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ikaopll_bus_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_bus_sequencer.sv
// Host-side write scheduler for the IKAOPLL core: queues (address, data) writes and
// replays them on CS_n/WR_n/A0/D with strobe and recovery times counted in phiM ticks.
module ikaopll_bus_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned WR_PULSE       = 2,
    parameter int unsigned ADDR_WAIT      = 12,
    parameter int unsigned DATA_WAIT      = 84,
    parameter int unsigned SKIP_SAME_ADDR = 0
) (
    input  logic                          i_EMUCLK,
    input  logic                          i_RST,
    input  logic                          i_phiM_PCEN_n,
    input  logic                          i_REQ_VALID,
    output logic                          o_REQ_READY,
    input  logic [7:0]                    i_REQ_ADDR,
    input  logic [7:0]                    i_REQ_DATA,
    output logic                          o_CS_n,
    output logic                          o_WR_n,
    output logic                          o_A0,
    output logic [7:0]                    o_D,
    output logic                          o_BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_LEVEL
);

    localparam int unsigned PW     = $clog2(FIFO_DEPTH);
    localparam int unsigned LW     = PW + 1;
    localparam int unsigned MAX_TW = (WR_PULSE > ADDR_WAIT)
                                   ? ((WR_PULSE > DATA_WAIT) ? WR_PULSE : DATA_WAIT)
                                   : ((ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT);
    localparam int unsigned CW     = $clog2(MAX_TW) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_STB,
        S_ADDR_WAIT,
        S_DATA_STB,
        S_DATA_WAIT
    } state_t;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          busy_q, busy_d;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          cs_n_q, wr_n_q, a0_q;
    logic [7:0]    d_q;
    logic [7:0]    cur_addr_q, cur_data_q;
    logic [7:0]    last_addr_q;
    logic          last_valid_q;

    logic          push, pop, tick, cnt_done, skip_hit, fsm_to_idle;
    logic [7:0]    head_addr, head_data;

    assign o_REQ_READY = (level_q < LW'(FIFO_DEPTH)) & ~i_RST;
    assign push        = i_REQ_VALID & o_REQ_READY;
    assign pop         = (state_q == S_IDLE) && (level_q != '0);
    assign tick        = ~i_phiM_PCEN_n;
    assign cnt_done    = tick && (cnt_q == CW'(1));
    assign head_addr   = mem_q[rd_ptr_q][15:8];
    assign head_data   = mem_q[rd_ptr_q][7:0];
    assign skip_hit    = (SKIP_SAME_ADDR != 0) && last_valid_q && (head_addr == last_addr_q);

    // The FSM stays in (or returns to) IDLE only when nothing is popped this edge.
    assign fsm_to_idle = (state_q == S_IDLE) ? (level_q == '0)
                                             : ((state_q == S_DATA_WAIT) && cnt_done);

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        busy_d = !fsm_to_idle || (level_d != '0);
    end

    always_ff @(posedge i_EMUCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_REQ_ADDR, i_REQ_DATA};
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cs_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            a0_q         <= 1'b0;
            d_q          <= 8'h00;
            cur_addr_q   <= 8'h00;
            cur_data_q   <= 8'h00;
            last_addr_q  <= 8'h00;
            last_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cur_addr_q <= head_addr;
                        cur_data_q <= head_data;
                        cs_n_q     <= 1'b0;
                        wr_n_q     <= 1'b0;
                        cnt_q      <= CW'(WR_PULSE);
                        if (skip_hit) begin
                            state_q <= S_DATA_STB;
                            a0_q    <= 1'b1;
                            d_q     <= head_data;
                        end else begin
                            state_q <= S_ADDR_STB;
                            a0_q    <= 1'b0;
                            d_q     <= head_addr;
                        end
                    end
                end
                S_ADDR_STB: begin
                    if (cnt_done) begin
                        cs_n_q       <= 1'b1;
                        wr_n_q       <= 1'b1;
                        last_addr_q  <= cur_addr_q;
                        last_valid_q <= 1'b1;
                        cnt_q        <= CW'(ADDR_WAIT);
                        state_q      <= S_ADDR_WAIT;
                    end else if (tick) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_ADDR_WAIT: begin
                    if (cnt_done) begin
                        a0_q    <= 1'b1;
                        d_q     <= cur_data_q;
                        cs_n_q  <= 1'b0;
                        wr_n_q  <= 1'b0;
                        cnt_q   <= CW'(WR_PULSE);
                        state_q <= S_DATA_STB;
                    end else if (tick) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DATA_STB: begin
                    if (cnt_done) begin
                        cs_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        cnt_q   <= CW'(DATA_WAIT);
                        state_q <= S_DATA_WAIT;
                    end else if (tick) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DATA_WAIT: begin
                    if (cnt_done) begin
                        state_q <= S_IDLE;
                    end else if (tick) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_CS_n       = cs_n_q;
    assign o_WR_n       = wr_n_q;
    assign o_A0         = a0_q;
    assign o_D          = d_q;
    assign o_BUSY       = busy_q;
    assign o_FIFO_LEVEL = level_q;

endmodule

// File: tb/tb_ikaopll_bus_sequencer.sv
// Directed bench for ikaopll_bus_sequencer: one instance with defaults and one with
// same-address skipping, sharing all inputs; strobes are logged as {A0, D} per falling CS_n.
module tb_ikaopll_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pcen = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data = 8'h00;

    logic       a_ready, a_cs, a_wr, a_a0, a_busy;
    logic [7:0] a_d;
    logic [2:0] a_level;
    logic       b_ready, b_cs, b_wr, b_a0, b_busy;
    logic [7:0] b_d;
    logic [2:0] b_level;

    int n_cmp = 0;
    int n_fail = 0;

    logic [11:0] rec_a [0:511];
    logic [11:0] rec_b [0:511];
    logic [8:0]  mon_a [$];
    logic [8:0]  mon_b [$];
    logic        prev_a = 1'b1;
    logic        prev_b = 1'b1;

    always #5 clk = ~clk;

    ikaopll_bus_sequencer u_dut (
        .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(pcen),
        .i_REQ_VALID(valid), .o_REQ_READY(a_ready),
        .i_REQ_ADDR(addr), .i_REQ_DATA(data),
        .o_CS_n(a_cs), .o_WR_n(a_wr), .o_A0(a_a0), .o_D(a_d),
        .o_BUSY(a_busy), .o_FIFO_LEVEL(a_level)
    );

    ikaopll_bus_sequencer #(.SKIP_SAME_ADDR(1)) u_skip (
        .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(pcen),
        .i_REQ_VALID(valid), .o_REQ_READY(b_ready),
        .i_REQ_ADDR(addr), .i_REQ_DATA(data),
        .o_CS_n(b_cs), .o_WR_n(b_wr), .o_A0(b_a0), .o_D(b_d),
        .o_BUSY(b_busy), .o_FIFO_LEVEL(b_level)
    );

    always @(negedge clk) begin
        if (a_cs === 1'b0 && prev_a === 1'b1) mon_a.push_back({a_a0, a_d});
        if (b_cs === 1'b0 && prev_b === 1'b1) mon_b.push_back({b_a0, b_d});
        prev_a = a_cs;
        prev_b = b_cs;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; pcen = 1'b0;
        tick(); tick();
        rst = 1'b0;
        mon_a.delete();
        mon_b.delete();
        tick();
    endtask

    task automatic run_cycles(input int n, input int period);
        for (int k = 1; k <= n; k++) begin
            tick();
            rec_a[k] = {a_busy, a_cs, a_wr, a_a0, a_d};
            rec_b[k] = {b_busy, b_cs, b_wr, b_a0, b_d};
            pcen = (period <= 1) ? 1'b0 : (((k % period) == 0) ? 1'b0 : 1'b1);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((a_busy !== 1'b0 || b_busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s_drain: busy a=%b b=%b after %0d clocks, required 0", name, a_busy, b_busy, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; addr = 8'hFF; data = 8'hFF; pcen = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({a_cs, a_wr, a_a0, a_d, a_busy, a_level, a_ready} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: cs=%b wr=%b a0=%b d=%h busy=%b lvl=%0d rdy=%b, required 1 1 0 00 0 0 0",
                     a_cs, a_wr, a_a0, a_d, a_busy, a_level, a_ready);
        end
        n_cmp++;
        if ({b_cs, b_wr, b_a0, b_d, b_busy, b_level, b_ready} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b: cs=%b wr=%b a0=%b d=%h busy=%b lvl=%0d rdy=%b, required 1 1 0 00 0 0 0",
                     b_cs, b_wr, b_a0, b_d, b_busy, b_level, b_ready);
        end
        valid = 1'b0; rst = 1'b0;
        tick();
        n_cmp++;
        if ({a_ready, a_level, a_busy} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b lvl=%0d busy=%b, required 1 0 0", a_ready, a_level, a_busy);
        end
    endtask

    task automatic test_single_write();
        logic [11:0] exp;
        do_reset();
        addr = 8'h10; data = 8'h55; valid = 1'b1;
        tick();
        valid = 1'b0;
        run_cycles(110, 1);
        for (int k = 1; k <= 110; k++) begin
            if (k <= 2)       exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'h10};
            else if (k <= 14) exp = {1'b1, 1'b1, 1'b1, 1'b0, 8'h10};
            else if (k <= 16) exp = {1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
            else              exp = {(k <= 100), 1'b1, 1'b1, 1'b1, 8'h55};
            n_cmp++;
            if (rec_a[k] !== exp) begin
                n_fail++;
                $display("FAIL single_a clk %0d: {busy,cs,wr,a0,d}=%h, required %h", k, rec_a[k], exp);
            end
            n_cmp++;
            if (rec_b[k] !== exp) begin
                n_fail++;
                $display("FAIL single_b clk %0d: {busy,cs,wr,a0,d}=%h, required %h", k, rec_b[k], exp);
            end
        end
    endtask

    task automatic test_slow_tick();
        logic [11:0] exp;
        do_reset();
        pcen = 1'b1;
        addr = 8'h10; data = 8'h55; valid = 1'b1;
        tick();
        valid = 1'b0;
        pcen = 1'b1;
        run_cycles(410, 4);
        pcen = 1'b0;
        for (int k = 1; k <= 410; k++) begin
            if (k <= 8)       exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'h10};
            else if (k <= 56) exp = {1'b1, 1'b1, 1'b1, 1'b0, 8'h10};
            else if (k <= 64) exp = {1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
            else              exp = {(k <= 400), 1'b1, 1'b1, 1'b1, 8'h55};
            n_cmp++;
            if (rec_a[k] !== exp) begin
                n_fail++;
                $display("FAIL slow_tick clk %0d: {busy,cs,wr,a0,d}=%h, required %h", k, rec_a[k], exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        logic [8:0] got, exp;
        do_reset();
        valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            addr = 8'h30 + 8'(i);
            data = 8'hA0 + 8'(i);
            guard = 0;
            while (a_ready !== 1'b1 && guard < 500) begin
                tick();
                guard++;
            end
            n_cmp++;
            if (guard >= 500) begin
                n_fail++;
                $display("FAIL b2b_ready_wait req %0d: ready=%b, required 1 within 500 clocks", i, a_ready);
            end
            tick();
            if (i == 3) begin
                n_cmp++;
                if ({a_level, a_ready} !== {3'd3, 1'b1}) begin
                    n_fail++;
                    $display("FAIL b2b_level3: lvl=%0d rdy=%b, required 3 1", a_level, a_ready);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if ({a_level, a_ready} !== {3'd4, 1'b0}) begin
                    n_fail++;
                    $display("FAIL b2b_full: lvl=%0d rdy=%b, required 4 0", a_level, a_ready);
                end
            end
        end
        valid = 1'b0;
        wait_idle(1500, "b2b");
        n_cmp++;
        if (mon_a.size() != 12 || mon_b.size() != 12) begin
            n_fail++;
            $display("FAIL b2b_count: strobes a=%0d b=%0d, required 12", mon_a.size(), mon_b.size());
        end
        for (int i = 0; i < 12; i++) begin
            exp = (i % 2 == 0) ? {1'b0, 8'h30 + 8'(i / 2)} : {1'b1, 8'hA0 + 8'(i / 2)};
            got = (i < mon_a.size()) ? mon_a[i] : 9'h1FF;
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL b2b_order strobe %0d: {a0,d}=%h, required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_skip_same_addr();
        logic [8:0] exp_a [6];
        logic [8:0] exp_b [5];
        logic [7:0] wa [3];
        logic [7:0] wd [3];
        logic [8:0] got;
        exp_a = '{9'h020, 9'h101, 9'h020, 9'h102, 9'h021, 9'h103};
        exp_b = '{9'h020, 9'h101, 9'h102, 9'h021, 9'h103};
        wa = '{8'h20, 8'h20, 8'h21};
        wd = '{8'h01, 8'h02, 8'h03};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            addr = wa[i]; data = wd[i]; valid = 1'b1;
            n_cmp++;
            if ((a_ready & b_ready) !== 1'b1) begin
                n_fail++;
                $display("FAIL skip_ready req %0d: a=%b b=%b, required 1", i, a_ready, b_ready);
            end
            tick();
        end
        valid = 1'b0;
        wait_idle(600, "skip");
        n_cmp++;
        if (mon_b.size() != 5) begin
            n_fail++;
            $display("FAIL skip_count_b: %0d strobes, required 5", mon_b.size());
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < mon_b.size()) ? mon_b[i] : 9'h1FF;
            n_cmp++;
            if (got !== exp_b[i]) begin
                n_fail++;
                $display("FAIL skip_seq_b strobe %0d: {a0,d}=%h, required %h", i, got, exp_b[i]);
            end
        end
        n_cmp++;
        if (mon_a.size() != 6) begin
            n_fail++;
            $display("FAIL noskip_count_a: %0d strobes, required 6", mon_a.size());
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < mon_a.size()) ? mon_a[i] : 9'h1FF;
            n_cmp++;
            if (got !== exp_a[i]) begin
                n_fail++;
                $display("FAIL noskip_seq_a strobe %0d: {a0,d}=%h, required %h", i, got, exp_a[i]);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] wa [3];
        logic [7:0] wd [3];
        logic [8:0] got;
        wa = '{8'h40, 8'h41, 8'h42};
        wd = '{8'h11, 8'h22, 8'h33};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            addr = wa[i]; data = wd[i]; valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if ({a_level, b_level, a_cs, b_cs} !== {3'd2, 3'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_pre: lvl a=%0d b=%0d cs a=%b b=%b, required 2 2 1 1", a_level, b_level, a_cs, b_cs);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_ready, b_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_ready: a=%b b=%b, required 0 0", a_ready, b_ready);
        end
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({a_cs, a_wr, a_level, a_busy} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_a: cs=%b wr=%b lvl=%0d busy=%b, required 1 1 0 0", a_cs, a_wr, a_level, a_busy);
        end
        n_cmp++;
        if ({b_cs, b_wr, b_level, b_busy} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_b: cs=%b wr=%b lvl=%0d busy=%b, required 1 1 0 0", b_cs, b_wr, b_level, b_busy);
        end
        for (int k = 0; k < 300; k++) tick();
        n_cmp++;
        if (mon_a.size() != 1 || mon_b.size() != 1 || mon_a[0] !== 9'h040) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: strobes a=%0d b=%0d, required 1 1 (addr 40 only)", mon_a.size(), mon_b.size());
        end
        mon_a.delete();
        mon_b.delete();
        addr = 8'h40; data = 8'h44; valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_idle(300, "rst_mid");
        got = (mon_b.size() > 0) ? mon_b[0] : 9'h1FF;
        n_cmp++;
        if (mon_b.size() != 2 || got !== 9'h040) begin
            n_fail++;
            $display("FAIL rst_mid_lastvalid: b strobes=%0d first=%h, required 2 040", mon_b.size(), got);
        end
        got = (mon_b.size() > 1) ? mon_b[1] : 9'h1FF;
        n_cmp++;
        if (got !== 9'h144) begin
            n_fail++;
            $display("FAIL rst_mid_data: b second strobe=%h, required 144", got);
        end
    endtask

    task automatic test_push_pop_same_edge();
        logic [7:0] wa [4];
        logic [7:0] wd [4];
        logic [8:0] got, exp;
        wa = '{8'h50, 8'h51, 8'h52, 8'h53};
        wd = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        do_reset();
        addr = wa[0]; data = wd[0]; valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        addr = wa[1]; data = wd[1]; valid = 1'b1;
        tick();
        addr = wa[2]; data = wd[2];
        tick();
        valid = 1'b0;
        for (int k = 0; k < 98; k++) tick();
        n_cmp++;
        if ({a_level, a_cs} !== {3'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL pp_before: lvl=%0d cs=%b, required 2 1", a_level, a_cs);
        end
        addr = wa[3]; data = wd[3]; valid = 1'b1;
        tick();
        valid = 1'b0;
        n_cmp++;
        if ({a_level, a_cs, a_a0, a_d} !== {3'd2, 1'b0, 1'b0, 8'h51}) begin
            n_fail++;
            $display("FAIL pp_edge: lvl=%0d cs=%b a0=%b d=%h, required 2 0 0 51", a_level, a_cs, a_a0, a_d);
        end
        wait_idle(1000, "pp");
        n_cmp++;
        if (mon_a.size() != 8) begin
            n_fail++;
            $display("FAIL pp_count: %0d strobes, required 8", mon_a.size());
        end
        for (int i = 0; i < 8; i++) begin
            exp = (i % 2 == 0) ? {1'b0, wa[i / 2]} : {1'b1, wd[i / 2]};
            got = (i < mon_a.size()) ? mon_a[i] : 9'h1FF;
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL pp_order strobe %0d: {a0,d}=%h, required %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_slow_tick();
        test_back_to_back();
        test_skip_same_addr();
        test_reset_mid_write();
        test_push_pop_same_edge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
